// File: rtl/tpu_pkg.sv
// Shared sizes, types and opcode decoding for the TPU matrix engine.
package tpu_pkg;

    localparam int MATRIX_WIDTH = 14;
    localparam int WEIGHT_ROWS  = 512;
    localparam int UB_ROWS      = 4096;
    localparam int ACC_ROWS     = 512;
    localparam int FIFO_DEPTH   = 16;

    localparam int WEIGHT_AW = $clog2(WEIGHT_ROWS);
    localparam int UB_AW     = $clog2(UB_ROWS);
    localparam int ACC_AW    = $clog2(ACC_ROWS);

    typedef logic [7:0]  byte_type;
    typedef logic [39:0] weight_addr_type;
    typedef logic [23:0] buffer_addr_type;
    typedef logic [15:0] acc_addr_type;

    typedef byte_type [MATRIX_WIDTH-1:0]    row_type;
    typedef logic [MATRIX_WIDTH-1:0][31:0]  acc_row_type;

    typedef struct packed {
        byte_type        opcode;
        logic [31:0]     length;
        buffer_addr_type buffer_addr;
        acc_addr_type    acc_addr;
    } instr_type;

    localparam instr_type INIT_INSTR = '0;

    localparam byte_type   NOP_OPCODE  = 8'h00;
    localparam byte_type   SYNC_OPCODE = 8'hFF;
    localparam byte_type   LOADW_MASK  = 8'hF8;
    localparam byte_type   LOADW_CODE  = 8'h08;
    localparam byte_type   MATMUL_MASK = 8'hE0;
    localparam byte_type   MATMUL_CODE = 8'h20;
    localparam logic [3:0] ACT_RELU    = 4'b1001;

    typedef enum logic [2:0] {OPC_NOP, OPC_LOADW, OPC_MATMUL, OPC_ACT, OPC_SYNC} op_class_type;
    typedef enum logic [1:0] {EX_IDLE, EX_LOADW, EX_MATMUL, EX_ACT} exec_state_type;

    // SYNC is checked first so 0xFF never falls into the ACT class; L=0 work degrades to NOP.
    function automatic op_class_type classify(input instr_type ins);
        op_class_type c;
        if (ins.opcode == SYNC_OPCODE) c = OPC_SYNC;
        else if ((ins.opcode == NOP_OPCODE) || (ins.length == 32'd0)) c = OPC_NOP;
        else if (ins.opcode[7]) c = OPC_ACT;
        else if ((ins.opcode & MATMUL_MASK) == MATMUL_CODE) c = OPC_MATMUL;
        else if ((ins.opcode & LOADW_MASK) == LOADW_CODE) c = OPC_LOADW;
        else c = OPC_NOP;
        return c;
    endfunction

    function automatic logic [31:0] extend_byte(input byte_type b, input logic sgn);
        return sgn ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

    function automatic byte_type activate(input logic [31:0] acc, input logic relu, input logic sgn);
        logic signed [31:0] v;
        byte_type r;
        v = $signed(acc);
        if (relu && (v < 32'sd0)) v = 32'sd0;
        else v = v;
        if (sgn) begin
            if (v > 32'sd127) r = 8'h7F;
            else if (v < -32'sd128) r = 8'h80;
            else r = v[7:0];
        end else begin
            if (v > 32'sd255) r = 8'hFF;
            else if (v < 32'sd0) r = 8'h00;
            else r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tpu_instr_fifo.sv
// Instruction FIFO with registered full/empty flags; pushes while full are dropped.
module tpu_instr_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  instr_type push_data,
    input  logic      pop,
    output instr_type head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);

    instr_type     mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [PW:0]   count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;
    assign head      = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) count_next_s = count_r + (PW+1)'(1);
        else if (!do_push_s && do_pop_s) count_next_s = count_r - (PW+1)'(1);
        else count_next_s = count_r;
    end

    // Entry storage, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    // Pointers and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r <= count_next_s;
            full_r  <= (count_next_s == (PW+1)'(DEPTH));
            empty_r <= (count_next_s == '0);
        end
    end

endmodule

// File: rtl/tpu_core.sv
// TPU matrix engine: host-loaded weight/UB memories and an in-order, one-row-per-cycle executor.
module tpu_core
    import tpu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [MATRIX_WIDTH-1:0][7:0]  weight_write_port,
    input  logic [39:0]                   weight_addr,
    input  logic                          weight_enable,
    input  logic [MATRIX_WIDTH-1:0]       weight_write_enable,
    input  logic [MATRIX_WIDTH-1:0][7:0]  buffer_write_port,
    output logic [MATRIX_WIDTH-1:0][7:0]  buffer_read_port,
    input  logic [23:0]                   buffer_addr,
    input  logic                          buffer_enable,
    input  logic [MATRIX_WIDTH-1:0]       buffer_write_enable,
    input  instr_type                     instr_port,
    input  logic                          instr_enable,
    output logic                          busy,
    output logic                          synchronize
);
    row_type     weight_mem [WEIGHT_ROWS];
    row_type     ub_mem [UB_ROWS];
    acc_row_type acc_mem [ACC_ROWS];

    instr_type      fifo_head_s;
    logic           fifo_empty_s;
    logic           pop_s;
    logic           step_s;
    op_class_type   head_class_s;
    exec_state_type state_r;
    exec_state_type state_next_s;
    instr_type      cur_r;
    logic [31:0]    row_r;
    logic [31:0]    row_last_r;
    logic [MATRIX_WIDTH-1:0][MATRIX_WIDTH-1:0][7:0] tile_r;
    logic           synchronize_r;
    row_type        buffer_read_r;
    logic [23:0]    ub_sum_s;
    logic [15:0]    acc_sum_s;
    row_type        x_row_s;
    row_type        w_row_s;
    row_type        act_row_s;
    acc_row_type    acc_rd_s;
    acc_row_type    mac_s;
    acc_row_type    acc_wdata_s;
    logic           unused_s;

    tpu_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (instr_enable),
        .push_data (instr_port),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (busy),
        .empty     (fifo_empty_s)
    );

    assign head_class_s     = classify(fifo_head_s);
    assign ub_sum_s         = cur_r.buffer_addr + row_r[23:0];
    assign acc_sum_s        = cur_r.acc_addr + row_r[15:0];
    assign x_row_s          = ub_mem[ub_sum_s[UB_AW-1:0]];
    assign w_row_s          = weight_mem[ub_sum_s[WEIGHT_AW-1:0]];
    assign acc_rd_s         = acc_mem[acc_sum_s[ACC_AW-1:0]];
    assign synchronize      = synchronize_r;
    assign buffer_read_port = buffer_read_r;
    assign unused_s = ^{weight_addr[39:WEIGHT_AW], buffer_addr[23:UB_AW], ub_sum_s[23:UB_AW],
                        acc_sum_s[15:ACC_AW], cur_r};

    // Executor next state: dispatch from idle, then one row per enabled cycle.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            EX_IDLE: begin
                if (enable && !fifo_empty_s) begin
                    pop_s = 1'b1;
                    case (head_class_s)
                        OPC_LOADW:  state_next_s = EX_LOADW;
                        OPC_MATMUL: state_next_s = EX_MATMUL;
                        OPC_ACT:    state_next_s = EX_ACT;
                        default:    state_next_s = EX_IDLE;
                    endcase
                end else begin
                    state_next_s = EX_IDLE;
                end
            end
            EX_LOADW, EX_MATMUL, EX_ACT: begin
                if (enable) begin
                    step_s = 1'b1;
                    if (row_r == row_last_r) state_next_s = EX_IDLE;
                    else state_next_s = state_r;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = EX_IDLE;
        endcase
    end

    // Row datapath: vector-matrix product, accumulate select and activation.
    always_comb begin
        mac_s       = '0;
        acc_wdata_s = '0;
        act_row_s   = '0;
        for (int j = 0; j < MATRIX_WIDTH; j++) begin
            for (int k = 0; k < MATRIX_WIDTH; k++) begin
                mac_s[j] = mac_s[j] + (extend_byte(x_row_s[k], cur_r.opcode[0]) *
                                       extend_byte(tile_r[k][j], cur_r.opcode[0]));
            end
            acc_wdata_s[j] = cur_r.opcode[1] ? (acc_rd_s[j] + mac_s[j]) : mac_s[j];
            act_row_s[j]   = activate(acc_rd_s[j], (cur_r.opcode[7:4] == ACT_RELU), cur_r.opcode[0]);
        end
    end

    // Executor registers; SYNC pulses on dispatch, when everything before it has retired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= EX_IDLE;
            cur_r         <= INIT_INSTR;
            row_r         <= 32'd0;
            row_last_r    <= 32'd0;
            tile_r        <= '0;
            synchronize_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            synchronize_r <= pop_s && (head_class_s == OPC_SYNC);
            if (pop_s) begin
                cur_r <= fifo_head_s;
                row_r <= 32'd0;
                if (head_class_s == OPC_LOADW) begin
                    tile_r     <= '0;
                    row_last_r <= (fifo_head_s.length > 32'(MATRIX_WIDTH)) ?
                                  32'(MATRIX_WIDTH - 1) : (fifo_head_s.length - 32'd1);
                end else begin
                    row_last_r <= fifo_head_s.length - 32'd1;
                end
            end else if (step_s) begin
                row_r <= row_r + 32'd1;
                if (state_r == EX_LOADW) tile_r[row_r[3:0]] <= w_row_s;
            end
        end
    end

    // Host weight port with per-byte enables.
    always_ff @(posedge clk) begin
        if (weight_enable) begin
            for (int j = 0; j < MATRIX_WIDTH; j++) begin
                if (weight_write_enable[j]) weight_mem[weight_addr[WEIGHT_AW-1:0]][j] <= weight_write_port[j];
            end
        end
    end

    // UB writes: the core write is issued last so it wins a same-byte collision.
    always_ff @(posedge clk) begin
        if (buffer_enable) begin
            for (int j = 0; j < MATRIX_WIDTH; j++) begin
                if (buffer_write_enable[j]) ub_mem[buffer_addr[UB_AW-1:0]][j] <= buffer_write_port[j];
            end
        end
        if (step_s && (state_r == EX_ACT)) ub_mem[ub_sum_s[UB_AW-1:0]] <= act_row_s;
    end

    // Accumulator writes from MATMUL rows.
    always_ff @(posedge clk) begin
        if (step_s && (state_r == EX_MATMUL)) acc_mem[acc_sum_s[ACC_AW-1:0]] <= acc_wdata_s;
    end

    // Host UB read register; returns pre-write data and holds between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) buffer_read_r <= '0;
        else if (buffer_enable) buffer_read_r <= ub_mem[buffer_addr[UB_AW-1:0]];
        else buffer_read_r <= buffer_read_r;
    end

endmodule

// File: tb/tb_tpu_core.sv
// Directed + randomized bench for tpu_core against an array-based behavioural model.
module tb_tpu_core;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [MATRIX_WIDTH-1:0][7:0] weight_write_port;
    logic [39:0] weight_addr;
    logic weight_enable;
    logic [MATRIX_WIDTH-1:0] weight_write_enable;
    logic [MATRIX_WIDTH-1:0][7:0] buffer_write_port;
    logic [MATRIX_WIDTH-1:0][7:0] buffer_read_port;
    logic [23:0] buffer_addr;
    logic buffer_enable;
    logic [MATRIX_WIDTH-1:0] buffer_write_enable;
    instr_type instr_port;
    logic instr_enable;
    logic busy;
    logic synchronize;

    int tests = 0;
    int fails = 0;
    int sync_cnt = 0;
    int exp_sync = 0;
    row_type last_row;

    logic [7:0] m_ub [UB_ROWS][MATRIX_WIDTH];
    logic [7:0] m_w [WEIGHT_ROWS][MATRIX_WIDTH];
    logic [7:0] m_tile [MATRIX_WIDTH][MATRIX_WIDTH];
    int         m_acc [ACC_ROWS][MATRIX_WIDTH];

    tpu_core dut (
        .clk(clk), .rst(rst), .enable(enable),
        .weight_write_port(weight_write_port), .weight_addr(weight_addr),
        .weight_enable(weight_enable), .weight_write_enable(weight_write_enable),
        .buffer_write_port(buffer_write_port), .buffer_read_port(buffer_read_port),
        .buffer_addr(buffer_addr), .buffer_enable(buffer_enable),
        .buffer_write_enable(buffer_write_enable),
        .instr_port(instr_port), .instr_enable(instr_enable),
        .busy(busy), .synchronize(synchronize)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (synchronize === 1'b1) sync_cnt <= sync_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic row_type rand_row();
        row_type r;
        for (int j = 0; j < MATRIX_WIDTH; j++) r[j] = 8'($urandom);
        return r;
    endfunction

    task automatic ub_write(input int addr, input row_type data, input logic [MATRIX_WIDTH-1:0] mask);
        buffer_addr = 24'(addr); buffer_write_port = data; buffer_write_enable = mask; buffer_enable = 1'b1;
        cycle();
        buffer_enable = 1'b0; buffer_write_enable = '0;
        for (int j = 0; j < MATRIX_WIDTH; j++) if (mask[j]) m_ub[addr % UB_ROWS][j] = data[j];
    endtask

    task automatic w_write(input int addr, input row_type data);
        weight_addr = 40'(addr); weight_write_port = data; weight_write_enable = '1; weight_enable = 1'b1;
        cycle();
        weight_enable = 1'b0; weight_write_enable = '0;
        for (int j = 0; j < MATRIX_WIDTH; j++) m_w[addr % WEIGHT_ROWS][j] = data[j];
    endtask

    task automatic check_ub_row(input string tag, input int addr);
        row_type exp;
        buffer_addr = 24'(addr); buffer_enable = 1'b1;
        cycle();
        buffer_enable = 1'b0;
        for (int j = 0; j < MATRIX_WIDTH; j++) exp[j] = m_ub[addr % UB_ROWS][j];
        last_row = buffer_read_port;
        check(tag, buffer_read_port, exp);
    endtask

    // Reference semantics, applied in program order at push time.
    task automatic model_exec(input logic [7:0] op, input int len, input int bufa, input int acca);
        int ui, ai, a, s, xv, wv;
        if (op == 8'hFF) begin
            exp_sync++;
        end else if (len == 0 || op == 8'h00) begin
            exp_sync = exp_sync;
        end else if (op[7]) begin
            for (int i = 0; i < len; i++) begin
                ui = (bufa + i) % UB_ROWS; ai = (acca + i) % ACC_ROWS;
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    a = m_acc[ai][j];
                    if (op[7:4] == 4'h9 && a < 0) a = 0;
                    if (op[0]) a = (a > 127) ? 127 : ((a < -128) ? -128 : a);
                    else a = (a > 255) ? 255 : ((a < 0) ? 0 : a);
                    m_ub[ui][j] = a[7:0];
                end
            end
        end else if (op[7:5] == 3'b001) begin
            for (int i = 0; i < len; i++) begin
                ui = (bufa + i) % UB_ROWS; ai = (acca + i) % ACC_ROWS;
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    s = 0;
                    for (int k = 0; k < MATRIX_WIDTH; k++) begin
                        xv = op[0] ? int'($signed(m_ub[ui][k])) : int'(m_ub[ui][k]);
                        wv = op[0] ? int'($signed(m_tile[k][j])) : int'(m_tile[k][j]);
                        s += xv * wv;
                    end
                    m_acc[ai][j] = op[1] ? m_acc[ai][j] + s : s;
                end
            end
        end else if (op[7:3] == 5'b00001) begin
            for (int i = 0; i < MATRIX_WIDTH; i++)
                for (int j = 0; j < MATRIX_WIDTH; j++)
                    m_tile[i][j] = (i < len) ? m_w[(bufa + i) % WEIGHT_ROWS][j] : 8'h00;
        end else begin
            exp_sync = exp_sync;
        end
    endtask

    task automatic push(input logic [7:0] op, input int len, input int bufa, input int acca, input bit model_it);
        instr_type ins;
        ins.opcode = op; ins.length = 32'(len); ins.buffer_addr = 24'(bufa); ins.acc_addr = 16'(acca);
        instr_port = ins; instr_enable = 1'b1;
        cycle();
        instr_enable = 1'b0;
        if (model_it) model_exec(op, len, bufa, acca);
    endtask

    task automatic wait_sync(input string tag);
        int n = 0;
        while (sync_cnt < exp_sync && n < 400) begin cycle(); n++; end
        repeat (3) cycle();
        check(tag, 128'(sync_cnt), 128'(exp_sync));
    endtask

    initial begin
        row_type r;
        rst = 1'b0; enable = 1'b0; instr_enable = 1'b0; instr_port = INIT_INSTR;
        weight_write_port = '0; weight_addr = '0; weight_enable = 1'b0; weight_write_enable = '0;
        buffer_write_port = '0; buffer_addr = '0; buffer_enable = 1'b0; buffer_write_enable = '0;
        cycle();
        rst = 1'b1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_sync", 128'(synchronize), 128'(0));
        check("rst_read", 128'(buffer_read_port), 128'(0));

        enable = 1'b1;
        ub_write(100, rand_row(), '1);
        repeat (20) cycle();
        check_ub_row("idle_hold", 100);
        check("idle_nosync", 128'(sync_cnt), 128'(0));

        for (int j = 0; j < MATRIX_WIDTH; j++) r[j] = 8'(j + 1);
        ub_write(5, r, '1);
        r[0] = 8'hAA;
        ub_write(5, r, 14'h0001);
        check_ub_row("ub_roundtrip", 5);
        check("ub_lane0", 128'(last_row[0]), 128'(8'hAA));
        check("ub_lane13", 128'(last_row[13]), 128'(8'd14));
        ub_write(UB_ROWS + 7, rand_row(), '1);
        check_ub_row("ub_host_wrap", 7);

        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            r = '0; r[i] = 8'd1; w_write(i, r);
            for (int j = 0; j < MATRIX_WIDTH; j++) r[j] = 8'(i + 1);
            ub_write(i, r, '1);
        end
        push(8'h09, 14, 0, 0, 1'b1);
        push(8'h21, 14, 0, 0, 1'b1);
        push(8'h99, 14, 14, 0, 1'b1);
        push(8'hFF, 1, 0, 0, 1'b1);
        wait_sync("ident_sync");
        for (int i = 14; i < 28; i++) check_ub_row($sformatf("ident_row%0d", i), i);

        for (int i = 0; i < MATRIX_WIDTH; i++) begin r = '0; r[i] = 8'd2; w_write(20 + i, r); end
        r = rand_row(); r[0] = 8'hFD; r[1] = 8'd100;
        ub_write(40, r, '1);
        push(8'h09, 14, 20, 0, 1'b1);
        push(8'h21, 1, 40, 5, 1'b1);
        push(8'h99, 1, 41, 5, 1'b1);
        push(8'hFF, 1, 0, 0, 1'b1);
        wait_sync("relu_sync");
        check_ub_row("relu_row", 41);
        check("relu_lane0", 128'(last_row[0]), 128'(8'd0));
        check("relu_lane1", 128'(last_row[1]), 128'(8'd127));

        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            for (int j = 0; j < MATRIX_WIDTH; j++) r[j] = 8'($urandom_range(0, 3));
            w_write(60 + i, r);
        end
        ub_write(49, '0, '1);
        for (int j = 0; j < MATRIX_WIDTH; j++) r[j] = 8'($urandom_range(0, 5));
        ub_write(50, r, '1);
        push(8'h08, 14, 60, 0, 1'b1);
        push(8'h21, 1, 49, 7, 1'b1);
        push(8'h23, 1, 50, 7, 1'b1);
        enable = 1'b0;
        repeat (6) cycle();
        enable = 1'b1;
        push(8'h23, 1, 50, 7, 1'b1);
        push(8'h21, 0, 50, 7, 1'b1);
        push(8'h89, 1, 51, 7, 1'b1);
        push(8'h89, 1, 24'hABCFFF, 16'hFE07, 1'b1);
        push(8'hFF, 1, 0, 0, 1'b1);
        wait_sync("accum_sync");
        check_ub_row("accum_row", 51);
        check_ub_row("accum_wrap", UB_ROWS - 1);

        ub_write(52, rand_row(), '1);
        push(8'h09, 3, 60, 0, 1'b1);
        push(8'h21, 1, 52, 9, 1'b1);
        push(8'h88, 1, 53, 9, 1'b1);
        push(8'hFF, 1, 0, 0, 1'b1);
        wait_sync("partial_sync");
        check_ub_row("partial_row", 53);

        for (int it = 0; it < 3; it++) begin
            int len, ub0, acc0;
            logic [7:0] mm0, mm1, act;
            len = $urandom_range(1, 4); ub0 = 200 + it * 20; acc0 = 100 + it * 10;
            mm0 = 8'h20 | 8'($urandom_range(0, 1));
            mm1 = 8'h20 | 8'($urandom_range(0, 7) << 2) | 8'($urandom_range(0, 1) << 1) | {7'd0, mm0[0]};
            act = 8'h80 | 8'($urandom_range(0, 7) << 4) | 8'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) ub_write(ub0 + i, rand_row(), '1);
            push(8'h08 | 8'($urandom_range(0, 7)), $urandom_range(1, 14), 60, 0, 1'b1);
            push(mm0, len, ub0, acc0, 1'b1);
            push(mm1, len, ub0, acc0, 1'b1);
            push(act, len, ub0 + 10, acc0, 1'b1);
            push(8'hFF, 1, 0, 0, 1'b1);
            wait_sync($sformatf("rand%0d_sync", it));
            for (int i = 0; i < len; i++) check_ub_row($sformatf("rand%0d_row%0d", it, i), ub0 + 10 + i);
        end

        enable = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) push(8'hFF, 1, 0, 0, 1'b1);
        check("bp_busy", 128'(busy), 128'(1));
        push(8'hFF, 1, 0, 0, 1'b0);
        check("bp_nosync", 128'(sync_cnt), 128'(exp_sync - FIFO_DEPTH));
        enable = 1'b1;
        cycle();
        check("bp_busy_drop", 128'(busy), 128'(0));
        wait_sync("bp_sync_count");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
